// File: rtl/proc_sys_reset_seq.sv
// Sequenced reset controller: filters several reset sources into one request and
// releases bus, peripheral and processor resets in order, recording the cause.
module proc_sys_reset_seq #(
  parameter int NUM_BUS_RST              = 1,
  parameter int NUM_PERP_RST             = 1,
  parameter int NUM_INTERCONNECT_ARESETN = 1,
  parameter int NUM_PERP_ARESETN         = 1,
  parameter int SYNC_STAGES              = 2,
  parameter int AUX_RESET_HIGH           = 1,
  parameter int AUX_RST_WIDTH            = 4,
  parameter int HOLD_CYCLES              = 16,
  parameter int STAGE_DLY                = 8
) (
  input  logic                                slowest_sync_clk,
  input  logic                                ext_reset_in,
  input  logic                                aux_reset_in,
  input  logic                                mb_debug_sys_rst,
  input  logic                                dcm_locked,
  input  logic                                sw_rst_req,
  output logic                                mb_reset,
  output logic [NUM_BUS_RST-1:0]              bus_struct_reset,
  output logic [NUM_PERP_RST-1:0]             peripheral_reset,
  output logic [NUM_INTERCONNECT_ARESETN-1:0] interconnect_aresetn,
  output logic [NUM_PERP_ARESETN-1:0]         peripheral_aresetn,
  output logic                                sw_rst_done,
  output logic [2:0]                          rst_state,
  output logic [3:0]                          rst_cause
);

  typedef enum logic [2:0] {
    HOLD     = 3'd0,
    REL_BUS  = 3'd1,
    REL_PERP = 3'd2,
    REL_MB   = 3'd3,
    RUN      = 3'd4
  } state_t;

  localparam int CNT_MAX    = (HOLD_CYCLES > STAGE_DLY) ? HOLD_CYCLES : STAGE_DLY;
  localparam int CW         = $clog2(CNT_MAX + 1);
  localparam int AW         = $clog2(AUX_RST_WIDTH + 1);
  localparam int STAGE_LAST = (STAGE_DLY > 0) ? STAGE_DLY - 1 : 0;

  state_t                 state, next_state;
  logic [SYNC_STAGES-1:0] rst_chain, aux_ff, dbg_ff, lock_ff, vld_ff;
  logic                   rst, aux_raw, aux_sync, dbg_sync, lock_sync, sync_vld;
  logic [AW-1:0]          aux_cnt;
  logic                   aux_rec, sw_acc, src_active, done_set, sw_pending;
  logic [3:0]             src_bits;
  logic [CW-1:0]          cnt;
  logic                   bus_n, perp_n, mb_n;

  always_ff @(posedge slowest_sync_clk or posedge ext_reset_in) begin
    if (ext_reset_in) rst_chain <= '1;
    else              rst_chain <= {rst_chain[SYNC_STAGES-2:0], 1'b0};
  end
  assign rst = rst_chain[SYNC_STAGES-1];

  assign aux_raw = (AUX_RESET_HIGH != 0) ? aux_reset_in : ~aux_reset_in;

  // Synchronisers come out of reset reporting "asserted"; vld_ff marks when they hold real samples.
  always_ff @(posedge slowest_sync_clk or posedge rst) begin
    if (rst) begin
      aux_ff  <= '1;
      dbg_ff  <= '1;
      lock_ff <= '0;
      vld_ff  <= '0;
    end else begin
      aux_ff  <= {aux_ff[SYNC_STAGES-2:0], aux_raw};
      dbg_ff  <= {dbg_ff[SYNC_STAGES-2:0], mb_debug_sys_rst};
      lock_ff <= {lock_ff[SYNC_STAGES-2:0], dcm_locked};
      vld_ff  <= {vld_ff[SYNC_STAGES-2:0], 1'b1};
    end
  end
  assign aux_sync  = aux_ff[SYNC_STAGES-1];
  assign dbg_sync  = dbg_ff[SYNC_STAGES-1];
  assign lock_sync = lock_ff[SYNC_STAGES-1];
  assign sync_vld  = vld_ff[SYNC_STAGES-1];

  always_ff @(posedge slowest_sync_clk or posedge rst) begin
    if (rst)                                       aux_cnt <= '0;
    else if (!(aux_sync && sync_vld))              aux_cnt <= '0;
    else if (aux_cnt != AW'(AUX_RST_WIDTH - 1))    aux_cnt <= aux_cnt + AW'(1);
    else                                           aux_cnt <= aux_cnt;
  end

  assign aux_rec    = aux_sync && sync_vld && (aux_cnt == AW'(AUX_RST_WIDTH - 1));
  assign sw_acc     = sw_rst_req && (state == RUN);
  assign src_bits   = {sw_acc, dbg_sync, ~lock_sync, aux_rec};
  assign src_active = |src_bits;

  always_ff @(posedge slowest_sync_clk or posedge rst) begin
    if (rst) state <= HOLD;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (src_active) begin
      next_state = HOLD;
    end else begin
      case (state)
        HOLD:     next_state = (cnt == CW'(HOLD_CYCLES - 1)) ? REL_BUS : HOLD;
        REL_BUS:  next_state = (cnt == CW'(STAGE_LAST)) ? REL_PERP : REL_BUS;
        REL_PERP: next_state = REL_MB;
        REL_MB:   next_state = RUN;
        RUN:      next_state = RUN;
        default:  next_state = HOLD;
      endcase
    end
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_comb begin
    bus_n  = 1'b1;
    perp_n = 1'b1;
    mb_n   = 1'b1;
    case (next_state)
      REL_BUS:  begin bus_n = 1'b0; perp_n = 1'b1; mb_n = 1'b1; end
      REL_PERP: begin bus_n = 1'b0; perp_n = 1'b0; mb_n = 1'b1; end
      REL_MB:   begin bus_n = 1'b0; perp_n = 1'b0; mb_n = 1'b0; end
      RUN:      begin bus_n = 1'b0; perp_n = 1'b0; mb_n = 1'b0; end
      default:  begin bus_n = 1'b1; perp_n = 1'b1; mb_n = 1'b1; end
    endcase
  end

  always_ff @(posedge slowest_sync_clk or posedge rst) begin
    if (rst)                                          cnt <= '0;
    else if (src_active || (next_state != state))     cnt <= '0;
    else if ((state == HOLD) || (state == REL_BUS))   cnt <= cnt + CW'(1);
    else                                              cnt <= cnt;
  end

  assign done_set = sw_pending && (next_state == RUN) && (state != RUN);

  always_ff @(posedge slowest_sync_clk or posedge rst) begin
    if (rst) begin
      mb_reset             <= 1'b1;
      bus_struct_reset     <= '1;
      peripheral_reset     <= '1;
      interconnect_aresetn <= '0;
      peripheral_aresetn   <= '0;
      sw_rst_done          <= 1'b0;
      sw_pending           <= 1'b0;
      rst_cause            <= 4'b0000;
    end else begin
      mb_reset             <= mb_n;
      bus_struct_reset     <= {NUM_BUS_RST{bus_n}};
      peripheral_reset     <= {NUM_PERP_RST{perp_n}};
      interconnect_aresetn <= {NUM_INTERCONNECT_ARESETN{~bus_n}};
      peripheral_aresetn   <= {NUM_PERP_ARESETN{~perp_n}};
      sw_rst_done          <= done_set;
      if (sw_acc)        sw_pending <= 1'b1;
      else if (done_set) sw_pending <= 1'b0;
      else               sw_pending <= sw_pending;
      // Warm-up samples are synchroniser reset values, not real causes.
      if ((state != HOLD) && src_active)   rst_cause <= src_bits;
      else if ((state == HOLD) && sync_vld) rst_cause <= rst_cause | src_bits;
      else                                  rst_cause <= rst_cause;
    end
  end

  assign rst_state = state;

endmodule

// File: tb/tb_proc_sys_reset_seq.sv
// Directed bench for proc_sys_reset_seq: default instance plus a STAGE_DLY = 0,
// widened-vector instance driven by the same inputs.
module tb_proc_sys_reset_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ext_reset_in = 1'b1;
  logic aux_reset_in = 1'b0;
  logic mb_debug_sys_rst = 1'b0;
  logic dcm_locked = 1'b1;
  logic sw_rst_req = 1'b0;

  logic       mb0, done0;
  logic [0:0] bus0, perp0, ic0, pa0;
  logic [2:0] st0;
  logic [3:0] cause0;

  logic       mb1, done1;
  logic [2:0] bus1;
  logic [0:0] perp1, ic1;
  logic [3:0] pa1;
  logic [2:0] st1;
  logic [3:0] cause1;

  int checks = 0;
  int failures = 0;

  proc_sys_reset_seq dut0 (
    .slowest_sync_clk(clk), .ext_reset_in(ext_reset_in), .aux_reset_in(aux_reset_in),
    .mb_debug_sys_rst(mb_debug_sys_rst), .dcm_locked(dcm_locked), .sw_rst_req(sw_rst_req),
    .mb_reset(mb0), .bus_struct_reset(bus0), .peripheral_reset(perp0),
    .interconnect_aresetn(ic0), .peripheral_aresetn(pa0), .sw_rst_done(done0),
    .rst_state(st0), .rst_cause(cause0)
  );

  proc_sys_reset_seq #(.NUM_BUS_RST(3), .NUM_PERP_ARESETN(4), .STAGE_DLY(0)) dut1 (
    .slowest_sync_clk(clk), .ext_reset_in(ext_reset_in), .aux_reset_in(aux_reset_in),
    .mb_debug_sys_rst(mb_debug_sys_rst), .dcm_locked(dcm_locked), .sw_rst_req(sw_rst_req),
    .mb_reset(mb1), .bus_struct_reset(bus1), .peripheral_reset(perp1),
    .interconnect_aresetn(ic1), .peripheral_aresetn(pa1), .sw_rst_done(done1),
    .rst_state(st1), .rst_cause(cause1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_mb", 32'(mb0), 32'd1);
    chk("rst_bus", 32'(bus0), 32'd1);
    chk("rst_ic", 32'(ic0), 32'd0);
    chk("rst_perp", 32'(perp0), 32'd1);
    chk("rst_pa", 32'(pa0), 32'd0);
    chk("rst_state", 32'(st0), 32'd0);
    chk("rst_cause", 32'(cause0), 32'd0);
    chk("rst_done", 32'(done0), 32'd0);
    chk("rst_bus1", 32'(bus1), 32'h7);
    chk("rst_pa1", 32'(pa1), 32'h0);

    // Power-up release; R = this edge.
    ext_reset_in = 1'b0;
    repeat (19) tick();
    chk("pu_bus_hold", 32'(bus0), 32'd1);
    chk("pu_state_hold", 32'(st0), 32'd0);
    tick();
    chk("pu_bus_rel", 32'(bus0), 32'd0);
    chk("pu_ic_rel", 32'(ic0), 32'd1);
    chk("pu_perp_held", 32'(perp0), 32'd1);
    chk("pu_mb_held", 32'(mb0), 32'd1);
    chk("pu_state1", 32'(st0), 32'd1);
    chk("d1_bus_rel", 32'(bus1), 32'h0);
    chk("d1_ic_rel", 32'(ic1), 32'd1);
    chk("d1_perp_held", 32'(perp1), 32'd1);
    tick();
    chk("d1_perp_rel", 32'(perp1), 32'd0);
    chk("d1_pa_rel", 32'(pa1), 32'hf);
    chk("d1_mb_held", 32'(mb1), 32'd1);
    chk("d1_state2", 32'(st1), 32'd2);
    tick();
    chk("d1_mb_rel", 32'(mb1), 32'd0);
    chk("d1_state3", 32'(st1), 32'd3);
    tick();
    chk("d1_run", 32'(st1), 32'd4);
    repeat (4) tick();
    chk("pu_perp_b7", 32'(perp0), 32'd1);
    chk("pu_state_b7", 32'(st0), 32'd1);
    tick();
    chk("pu_perp_rel", 32'(perp0), 32'd0);
    chk("pu_pa_rel", 32'(pa0), 32'd1);
    chk("pu_mb_b8", 32'(mb0), 32'd1);
    chk("pu_state2", 32'(st0), 32'd2);
    tick();
    chk("pu_mb_rel", 32'(mb0), 32'd0);
    chk("pu_state3", 32'(st0), 32'd3);
    tick();
    chk("pu_run", 32'(st0), 32'd4);
    chk("pu_cause", 32'(cause0), 32'd0);
    chk("pu_no_done", 32'(done0), 32'd0);

    // Aux pulse of 3 cycles: filtered out.
    aux_reset_in = 1'b1;
    repeat (3) tick();
    aux_reset_in = 1'b0;
    repeat (6) tick();
    chk("aux3_state", 32'(st0), 32'd4);
    chk("aux3_mb", 32'(mb0), 32'd0);

    // Aux pulse of 4 cycles; A = this edge.
    aux_reset_in = 1'b1;
    repeat (4) tick();
    aux_reset_in = 1'b0;
    tick();
    chk("aux4_pre_state", 32'(st0), 32'd4);
    tick();
    chk("aux4_state", 32'(st0), 32'd0);
    chk("aux4_mb", 32'(mb0), 32'd1);
    chk("aux4_bus", 32'(bus0), 32'd1);
    chk("aux4_ic", 32'(ic0), 32'd0);
    chk("aux4_cause", 32'(cause0), 32'h1);
    repeat (15) tick();
    chk("aux4_bus_hold", 32'(bus0), 32'd1);
    tick();
    chk("aux4_bus_rel", 32'(bus0), 32'd0);
    chk("aux4_state1", 32'(st0), 32'd1);

    // Lock drop timed to land in REL_PERP; B = bus release edge above.
    repeat (6) tick();
    dcm_locked = 1'b0;
    repeat (2) tick();
    chk("lk_in_perp", 32'(st0), 32'd2);
    chk("lk_perp_rel", 32'(perp0), 32'd0);
    tick();
    chk("lk_state", 32'(st0), 32'd0);
    chk("lk_bus", 32'(bus0), 32'd1);
    chk("lk_ic", 32'(ic0), 32'd0);
    chk("lk_perp", 32'(perp0), 32'd1);
    chk("lk_cause", 32'(cause0), 32'h2);
    dcm_locked = 1'b1;
    repeat (17) tick();
    chk("lk_bus_hold", 32'(bus0), 32'd1);
    chk("lk_state_hold", 32'(st0), 32'd0);
    tick();
    chk("lk_bus_rel", 32'(bus0), 32'd0);
    chk("lk_state1", 32'(st0), 32'd1);
    repeat (10) tick();
    chk("lk_run", 32'(st0), 32'd4);
    chk("lk_mb_rel", 32'(mb0), 32'd0);

    // Software reset; P = this edge.
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    chk("sw_state", 32'(st0), 32'd0);
    chk("sw_mb", 32'(mb0), 32'd1);
    chk("sw_bus", 32'(bus0), 32'd1);
    chk("sw_cause", 32'(cause0), 32'h8);
    chk("sw_d1_state", 32'(st1), 32'd0);
    repeat (2) tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    chk("swhold_state", 32'(st0), 32'd0);
    chk("swhold_cause", 32'(cause0), 32'h8);
    repeat (12) tick();
    chk("sw_bus_hold", 32'(bus0), 32'd1);
    tick();
    chk("sw_bus_rel", 32'(bus0), 32'd0);
    repeat (3) tick();
    chk("sw_d1_done", 32'(done1), 32'd1);
    chk("sw_d1_run", 32'(st1), 32'd4);
    repeat (6) tick();
    chk("sw_done_pre", 32'(done0), 32'd0);
    chk("sw_state3", 32'(st0), 32'd3);
    tick();
    chk("sw_done", 32'(done0), 32'd1);
    chk("sw_run", 32'(st0), 32'd4);
    tick();
    chk("sw_done_end", 32'(done0), 32'd0);

    // Ext reset with debug during REL_MB; Q = this edge.
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    repeat (25) tick();
    chk("ex_in_relmb", 32'(st0), 32'd3);
    chk("ex_mb_rel", 32'(mb0), 32'd0);
    ext_reset_in = 1'b1;
    mb_debug_sys_rst = 1'b1;
    #1;
    chk("ex_async_mb", 32'(mb0), 32'd1);
    chk("ex_async_bus", 32'(bus0), 32'd1);
    chk("ex_async_ic", 32'(ic0), 32'd0);
    chk("ex_async_pa", 32'(pa0), 32'd0);
    chk("ex_async_state", 32'(st0), 32'd0);
    chk("ex_async_cause", 32'(cause0), 32'd0);
    repeat (4) tick();
    ext_reset_in = 1'b0;
    repeat (10) tick();
    chk("ex_dbg_state", 32'(st0), 32'd0);
    chk("ex_dbg_cause", 32'(cause0), 32'h4);
    chk("ex_dbg_mb", 32'(mb0), 32'd1);
    mb_debug_sys_rst = 1'b0;
    repeat (28) tick();
    chk("ex_run", 32'(st0), 32'd4);
    chk("ex_no_done", 32'(done0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
